// File: rtl/dbus_ctrl.sv
// Data-bus transaction sequencer sitting between the memory stage and the
// data bus. Issues the memory-stage request with zero latency, holds it on
// the bus until addr_ok, waits for data_ok, stalls the pipeline meanwhile,
// and drains killed transactions instead of abandoning them mid-bus.

package dbus_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

module dbus_ctrl
  import dbus_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  dbus_req_t        req_in,
  input  logic             flush,
  output dbus_req_t        dreq,
  input  dbus_resp_t       dresp,
  output logic             stall,
  output logic             done,
  output logic [31:0]      rdata,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t      state_q;
  state_t      state_d;
  dbus_req_t   req_q;
  logic        abort_q;
  logic        abort_d;
  logic [31:0] rdata_q;
  logic        kill;
  logic        is_load;

  // Bus drive, stall/done generation and next-state selection.
  // Everything is forced to the reset state while reset is high.
  always_comb begin
    dreq    = '0;
    stall   = 1'b0;
    done    = 1'b0;
    state_d = state_q;
    abort_d = abort_q;
    kill    = flush | abort_q;
    is_load = (req_q.strobe == 4'h0);
    if (!reset) begin
      case (state_q)
        IDLE: begin
          // Zero-latency issue straight from the memory stage.
          is_load    = (req_in.strobe == 4'h0);
          dreq       = req_in;
          dreq.valid = req_in.valid & ~flush;
          abort_d    = 1'b0;
          if (req_in.valid && !flush) begin
            if (!dresp.addr_ok)      state_d = ADDR;
            else if (!dresp.data_ok) state_d = DATA;
            else                     done    = 1'b1;
          end
          stall = req_in.valid & ~flush & ~done;
        end
        ADDR: begin
          // Request stays on the bus even when killed; the abort is remembered.
          dreq       = req_q;
          dreq.valid = 1'b1;
          abort_d    = kill;
          if (dresp.addr_ok) begin
            abort_d = 1'b0;
            if (dresp.data_ok) begin
              state_d = IDLE;
              done    = ~kill;
            end else begin
              state_d = kill ? DRAIN : DATA;
            end
          end
          stall = req_in.valid & ~flush & ~done;
        end
        DATA: begin
          dreq       = req_q;
          dreq.valid = 1'b0;
          if (dresp.data_ok) begin
            state_d = IDLE;
            done    = ~flush;
          end else if (flush) begin
            state_d = DRAIN;
          end
          stall = req_in.valid & ~flush & ~done;
        end
        DRAIN: begin
          // Killed transaction: wait out data_ok and throw the data away.
          dreq       = req_q;
          dreq.valid = 1'b0;
          stall      = 1'b1;
          if (dresp.data_ok) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (reset)               rdata = '0;
    else if (done && is_load) rdata = dresp.data;
    else                     rdata = rdata_q;
  end

  // State, latched request, held load data and stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      abort_q   <= 1'b0;
      rdata_q   <= '0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      if (state_q == IDLE && req_in.valid) req_q <= req_in;
      if (done && is_load) rdata_q <= dresp.data;
      if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Scoreboard bench for dbus_ctrl: a transaction-level model predicts every
// cycle's outputs and every completion; a monitor compares on the falling edge.

module tb_dbus_ctrl;
  import dbus_pkg::*;

  logic        clk;
  logic        reset;
  dbus_req_t   req_in;
  logic        flush;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic [31:0] stall_cnt;

  dbus_req_t   dreq4;
  logic        stall4;
  logic        done4;
  logic [31:0] rdata4;
  logic [3:0]  stall_cnt4;

  dbus_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .flush(flush),
    .dreq(dreq), .dresp(dresp), .stall(stall), .done(done),
    .rdata(rdata), .stall_cnt(stall_cnt)
  );

  dbus_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .req_in(req_in), .flush(flush),
    .dreq(dreq4), .dresp(dresp), .stall(stall4), .done(done4),
    .rdata(rdata4), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        chk_cnt;
    logic        dv;
    dbus_req_t   dr;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic [31:0] cnt;
  } exp_t;

  exp_t        cq[$];
  logic [31:0] evq[$];

  int tests = 0;
  int fails = 0;

  // Transaction-level model: is a transaction outstanding, does it still
  // need its address phase, has it been killed.
  logic        m_pend = 1'b0;
  logic        m_need_addr = 1'b0;
  logic        m_killed = 1'b0;
  dbus_req_t   m_tx = '0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_cnt = '0;
  logic        m_known = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cycle(input logic r, input dbus_req_t rq, input logic fl,
                       input logic ao, input logic dk, input logic [31:0] dat,
                       output logic st);
    exp_t e;
    logic drain, ld, k, issue;
    e = '{default: '0};
    e.rst     = r;
    e.chk_cnt = m_known;
    ld        = 1'b0;
    if (r) begin
      e.cnt       = m_cnt;
      m_pend      = 1'b0;
      m_need_addr = 1'b0;
      m_killed    = 1'b0;
      m_rdata     = '0;
      m_cnt       = '0;
      m_known     = 1'b1;
      e.rdata     = '0;
    end else begin
      drain = m_pend && !m_need_addr && m_killed;
      if (!m_pend) begin
        issue      = rq.valid && !fl;
        e.dv       = issue;
        e.dr       = rq;
        e.dr.valid = issue;
        ld         = (rq.strobe == 4'h0);
        if (issue) begin
          m_tx = rq;
          if (ao && dk) e.done = 1'b1;
          else begin
            m_pend      = 1'b1;
            m_need_addr = !ao;
            m_killed    = 1'b0;
          end
        end
      end else if (m_need_addr) begin
        e.dv       = 1'b1;
        e.dr       = m_tx;
        e.dr.valid = 1'b1;
        ld         = (m_tx.strobe == 4'h0);
        k          = m_killed || fl;
        if (ao && dk) begin
          e.done = !k;
          m_pend = 1'b0;
        end else begin
          m_killed = k;
          if (ao) m_need_addr = 1'b0;
        end
      end else begin
        ld = (m_tx.strobe == 4'h0);
        k  = m_killed || fl;
        if (dk) begin
          e.done = !k;
          m_pend = 1'b0;
        end else begin
          m_killed = k;
        end
      end
      e.stall = drain ? 1'b1 : (rq.valid && !fl && !e.done);
      if (e.done && ld) m_rdata = dat;
      e.rdata = m_rdata;
      e.cnt   = m_cnt;
      if (e.stall) m_cnt = m_cnt + 1;
      if (e.done) evq.push_back(e.rdata);
    end
    st     = e.stall;
    reset  = r;
    req_in = rq;
    flush  = fl;
    dresp  = '{addr_ok: ao, data_ok: dk, data: dat};
    cq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t x;
    if (cq.size() != 0) begin
      x = cq.pop_front();
      chk("stall", 128'(stall), 128'(x.stall));
      chk("done", 128'(done), 128'(x.done));
      chk("dreq_valid", 128'(dreq.valid), 128'(x.dv));
      if (x.dv) chk("dreq_fields", 128'(dreq), 128'(x.dr));
      if (x.rst) chk("dreq_reset", 128'(dreq), 128'(0));
      chk("rdata", 128'(rdata), 128'(x.rdata));
      if (x.chk_cnt) begin
        chk("stall_cnt", 128'(stall_cnt), 128'(x.cnt));
        chk("stall_cnt_w4", 128'(stall_cnt4), 128'(x.cnt[3:0]));
      end
      if (done) begin
        if (evq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_event: got done=1, expected no completion at %0t", $time);
        end else begin
          chk("done_rdata", 128'(rdata), 128'(evq.pop_front()));
        end
      end
    end
  end

  function automatic dbus_req_t mk(input logic v, input logic [31:0] a,
                                   input logic [3:0] sb, input logic [31:0] d);
    dbus_req_t r;
    r.valid = v; r.addr = a; r.size = 3'd2; r.strobe = sb; r.data = d;
    return r;
  endfunction

  function automatic dbus_req_t rnd_req();
    dbus_req_t r;
    r.valid  = ($urandom_range(0, 9) < 7);
    r.addr   = $urandom;
    r.size   = 3'($urandom_range(0, 2));
    r.strobe = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
    r.data   = $urandom;
    return r;
  endfunction

  initial begin
    dbus_req_t idle, ld1, st1, alt, rq;
    logic st;
    idle  = '0;
    reset = 1'b1; req_in = '0; flush = 1'b0; dresp = '0;
    @(posedge clk);
    #1;
    cycle(1, idle, 0, 0, 0, 0, st);
    cycle(1, idle, 0, 0, 0, 0, st);

    // Single-cycle load.
    ld1 = mk(1, 32'h8000_0010, 4'h0, 32'h0);
    cycle(0, ld1, 0, 1, 1, 32'hDEAD_BEEF, st);
    cycle(0, idle, 0, 0, 1, 32'h0BAD_0BAD, st);

    // Store with delayed addr_ok and data_ok.
    st1 = mk(1, 32'h8000_0020, 4'hF, 32'h1234_5678);
    cycle(0, st1, 0, 0, 0, 0, st);
    cycle(0, st1, 0, 0, 0, 0, st);
    cycle(0, st1, 0, 0, 0, 0, st);
    cycle(0, st1, 0, 1, 0, 0, st);
    cycle(0, st1, 0, 0, 0, 0, st);
    cycle(0, st1, 0, 0, 1, 32'h5555_0000, st);
    cycle(0, idle, 0, 0, 0, 0, st);

    // Load whose memory-stage fields change while waiting for addr_ok.
    ld1 = mk(1, 32'h8000_0030, 4'h0, 32'h0);
    alt = mk(1, 32'h9999_0000, 4'h3, 32'h7777_7777);
    cycle(0, ld1, 0, 0, 0, 0, st);
    cycle(0, alt, 0, 0, 0, 0, st);
    cycle(0, alt, 0, 1, 1, 32'h1111_2222, st);

    // Flush while in DATA: drained, no completion, rdata held.
    ld1 = mk(1, 32'h8000_0040, 4'h0, 32'h0);
    cycle(0, ld1, 0, 1, 0, 0, st);
    cycle(0, ld1, 1, 0, 0, 0, st);
    cycle(0, idle, 0, 0, 0, 0, st);
    cycle(0, idle, 0, 0, 1, 32'hAAAA_5555, st);
    cycle(0, idle, 0, 0, 0, 0, st);

    // Reset while in DATA with data_ok arriving during reset.
    cycle(0, ld1, 0, 1, 0, 0, st);
    cycle(1, ld1, 0, 0, 1, 32'hCAFE_F00D, st);
    cycle(0, idle, 0, 0, 1, 32'hCAFE_F00D, st);

    // Back-to-back loads, each with a one-cycle addr_ok delay.
    ld1 = mk(1, 32'h8000_0050, 4'h0, 32'h0);
    cycle(0, ld1, 0, 0, 0, 0, st);
    cycle(0, ld1, 0, 1, 1, 32'h0000_00A1, st);
    ld1 = mk(1, 32'h8000_0054, 4'h0, 32'h0);
    cycle(0, ld1, 0, 0, 0, 0, st);
    cycle(0, ld1, 0, 1, 1, 32'h0000_00B2, st);
    cycle(0, idle, 0, 0, 0, 0, st);

    // Sixteen stall cycles from a fresh reset: narrow counter wraps to 0.
    cycle(1, idle, 0, 0, 0, 0, st);
    ld1 = mk(1, 32'h8000_0060, 4'h0, 32'h0);
    for (int i = 0; i < 16; i++) cycle(0, ld1, 0, 0, 0, 0, st);
    cycle(0, ld1, 0, 1, 1, 32'h0600_0600, st);
    cycle(0, idle, 0, 0, 0, 0, st);

    // Randomised traffic; the pipeline holds its request while stalled.
    rq = '0;
    st = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic r, fl, ao, dk;
      if (!st) rq = rnd_req();
      r  = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 9) == 0);
      ao = ($urandom_range(0, 1) == 1);
      dk = ($urandom_range(0, 1) == 1);
      cycle(r, rq, fl, ao, dk, $urandom, st);
    end

    cycle(0, idle, 0, 0, 0, 0, st);
    @(negedge clk);
    #1;
    chk("expect_queue_empty", 128'(cq.size()), 128'(0));
    chk("done_queue_empty", 128'(evq.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dbus_ctrl.md
Name: dbus_ctrl

Overview:
- Data-bus transaction sequencer between the memory stage and the data bus.
- Takes the memory stage's combinational request (load or store), drives the bus handshake (addr_ok then data_ok), and holds the request stable until the bus accepts it.
- Stalls the pipeline until the transaction completes and returns load data.
- Handles flushes: a killed in-flight transaction is drained, never abandoned mid-bus.

Parameters:
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- req_in  in  dbus_req_t  memory-stage request; held stable by pipeline while stall=1
- flush  in  1  kill current memory-stage instruction
- dreq  out  dbus_req_t  request to data bus
- dresp  in  dbus_resp_t  bus response (addr_ok, data_ok, data)
- stall  out  1  hold memory stage and everything upstream
- done  out  1  transaction completed this cycle (not asserted for aborted ones)
- rdata  out  32  load data; valid when done=1, held until next done
- stall_cnt  out  CNT_W  cycles with stall=1 since reset

Behaviour:
- Reset (synchronous, active-high): state=IDLE, latched request=0, rdata=0, stall_cnt=0, dreq=0.
- While reset is high, outputs are driven by the reset state: stall=0, done=0.
- Reset mid-transaction drops everything immediately; no drain.
- States: IDLE, ADDR (waiting addr_ok), DATA (waiting data_ok), DRAIN (aborted, waiting data_ok).
- IDLE:
  - dreq = req_in passthrough, zero-latency issue.
  - If req_in.valid, latch req_in at the clock edge.
  - Next state when req_in.valid and flush=0:
    - addr_ok=0 -> ADDR
    - addr_ok=1, data_ok=0 -> DATA
    - addr_ok=1, data_ok=1 -> IDLE with done=1
  - req_in.valid with flush=1: no request is issued (dreq.valid=0), state stays IDLE.
- ADDR:
  - dreq = latched copy; valid held at 1 until addr_ok.
  - addr_ok=1 -> DATA, or IDLE with done=1 if data_ok arrives in the same cycle.
  - flush in ADDR: keep dreq.valid until addr_ok; abort is recorded.
    - addr_ok without data_ok -> DRAIN.
    - addr_ok with data_ok -> IDLE, done=0.
- DATA:
  - dreq.valid=0.
  - data_ok -> IDLE with done=1.
  - flush without data_ok -> DRAIN.
  - flush together with data_ok -> IDLE, done=0.
- DRAIN:
  - dreq.valid=0, done=0, stall=1.
  - data_ok -> IDLE; data discarded.
- Completion cycle (done=1):
  - rdata = dresp.data combinationally for loads (strobe==0); the value is also registered and held afterwards.
  - Stores (strobe!=0): done=1, rdata unchanged.
- stall is combinational:
  - In IDLE, ADDR, DATA: stall = req_in.valid & ~flush & ~completion_this_cycle.
  - In DRAIN: stall = 1.
  - Stall therefore drops in the completion cycle, and the pipeline advances at that edge.
- A new request may issue the cycle after returning to IDLE; there are no back-to-back bubbles beyond that.
- stall_cnt increments by 1 on every cycle with stall=1 and wraps at 2^CNT_W-1 -> 0.
- data_ok while in IDLE (spurious): ignored.
- addr_ok while dreq.valid=0: ignored.

Test Plan:
- Load addr 0x8000_0010, bus gives addr_ok+data_ok (data 0xDEAD_BEEF) in the same cycle as issue -> done=1 and rdata=0xDEAD_BEEF in cycle 0, stall never 1, stall_cnt=0.
- Store addr 0x8000_0020, strobe 0xF, data 0x1234_5678; addr_ok delayed 3 cycles, data_ok 2 cycles later -> dreq fields constant and valid=1 for 4 cycles, valid=0 afterwards, stall=1 for 5 cycles, done on cycle 5, stall_cnt=5.
- Load with req_in fields changed during ADDR (pipeline violation) -> dreq still shows the latched addr/size/strobe/data.
- Load reaches DATA, flush asserted, data_ok 2 cycles later with 0xAAAA_5555 -> DRAIN entered, done never 1, rdata keeps its previous value, stall=1 through DRAIN, state IDLE after.
- Reset asserted in DATA, data_ok arrives during reset -> all outputs at reset values next cycle, no done.
- Two back-to-back loads, each with a 1-cycle addr_ok delay -> second dreq.valid rises the cycle after the first done, rdata updates per load.
- stall_cnt wrap check with CNT_W=4 overridden -> after 16 stall cycles stall_cnt=0.
